// File: rtl/fft_bitrev_reorder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fft_bitrev_reorder_pkg
// Brief    : Shared helpers for the FFT bit-reversal reorder buffer:
//            bit-reverse and ceil-log2 functions, read FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package fft_bitrev_reorder_pkg;

    // Read-side FSM encoding
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_READ = 1'b1;

    // Reverse the low W bits of v; bits at and above W come back as zero.
    // A shift loop avoids variable part-selects, so it folds to pure wiring.
    function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
        logic [31:0] r;
        logic [31:0] t;
        r = '0;
        t = v;
        for (int i = 0; i < 32; i++) begin
            if (i < w) begin
                r = {r[30:0], t[0]};
                t = t >> 1;
            end
        end
        return r;
    endfunction

    // Smallest r such that 2**r >= v
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_bitrev_reorder_if.sv
`default_nettype none
// ============================================================================
// Module   : fft_bitrev_reorder_if
// Brief    : Sample stream into the reorder buffer (bit-reversed order) and
//            reordered stream out (natural bin order with bin index).
// Revision : 1.0 - initial release
// ============================================================================
interface fft_bitrev_reorder_if #(
    parameter int DATA_WIDTH = 25,
    parameter int N          = 1024
) ();
    import fft_bitrev_reorder_pkg::*;

    localparam int AW = clog2(N);

    logic                  en_i;
    logic [DATA_WIDTH-1:0] di;
    logic                  valid_o;
    logic [DATA_WIDTH-1:0] data_o;
    logic [AW-1:0]         ctr_o;

    // Upstream side: FFT butterfly output plus downstream consumer
    modport master (
        output en_i,
        output di,
        input  valid_o,
        input  data_o,
        input  ctr_o
    );

    // Reorder buffer side
    modport slave (
        input  en_i,
        input  di,
        output valid_o,
        output data_o,
        output ctr_o
    );

endinterface
`default_nettype wire

// File: rtl/fft_bitrev_reorder_sdp_ram.sv
`default_nettype none
// ============================================================================
// Module   : fft_bitrev_reorder_sdp_ram
// Brief    : Single-clock simple dual-port RAM, write-first, one-cycle
//            registered read, no output pipeline register (block RAM style).
// Revision : 1.0 - initial release
// ============================================================================
module fft_bitrev_reorder_sdp_ram
    import fft_bitrev_reorder_pkg::*;
#(
    parameter int DATA_WIDTH = 25,
    parameter int DEPTH      = 2048,
    parameter int AW         = clog2(DEPTH)
) (
    input  wire logic                  clk,
    input  wire logic                  we_i,
    input  wire logic [AW-1:0]         waddr_i,
    input  wire logic [DATA_WIDTH-1:0] wdata_i,
    input  wire logic                  re_i,
    input  wire logic [AW-1:0]         raddr_i,
    output      logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Write port
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read; a same-address write is forwarded (write-first)
    always_ff @(posedge clk) begin
        if (re_i) begin
            if (we_i && (waddr_i == raddr_i)) begin
                rdata_q <= wdata_i;
            end else begin
                rdata_q <= mem_q[raddr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/fft_bitrev_reorder.sv
`default_nettype none
// ============================================================================
// Module   : fft_bitrev_reorder
// Brief    : Ping-pong reorder buffer turning the bit-reversed FFT output
//            stream into natural bin order, one N-sample frame at a time.
//            Writes scatter to bitrev addresses, reads sweep linearly.
// Revision : 1.0 - initial release
// ============================================================================
module fft_bitrev_reorder
    import fft_bitrev_reorder_pkg::*;
#(
    parameter int DATA_WIDTH = 25,
    parameter int N          = 1024
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    fft_bitrev_reorder_if.slave    bus
);

    localparam int            AW     = clog2(N);
    localparam logic [AW-1:0] c_LAST = AW'(N - 1);
    localparam logic [AW-1:0] c_ONE  = AW'(1);

    // Write side
    logic [AW-1:0] wr_ctr_q;
    logic          wr_bank_q;
    logic [AW-1:0] w_wr_rev;
    logic          w_we;
    logic          w_drain_req;

    // Read side
    logic [0:0]    state_q, state_d;
    logic          rd_bank_q, rd_bank_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic          w_rd_en;

    // Output alignment
    logic                  valid_q;
    logic [AW-1:0]         ctr_q;
    logic [DATA_WIDTH-1:0] w_ram_rdata;

    assign w_wr_rev    = AW'(bitrev(32'(wr_ctr_q), AW));
    // Writes are held off while in reset so a discarded frame cannot land
    assign w_we        = bus.en_i & rst_n;
    assign w_drain_req = w_we && (wr_ctr_q == c_LAST);

    // Write counter and bank toggle; a completed frame flips the fill bank
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ctr_q  <= '0;
            wr_bank_q <= 1'b0;
        end else if (bus.en_i) begin
            wr_ctr_q <= wr_ctr_q + c_ONE;
            if (wr_ctr_q == c_LAST) begin
                wr_bank_q <= ~wr_bank_q;
            end
        end
    end

    // Read FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rd_bank_q <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            rd_bank_q <= rd_bank_d;
            rd_addr_q <= rd_addr_d;
        end
    end

    // Read FSM next state: sweep a bank, chain straight into the next frame
    always_comb begin
        state_d   = state_q;
        rd_bank_d = rd_bank_q;
        rd_addr_d = rd_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (w_drain_req) begin
                    state_d   = ST_READ;
                    rd_bank_d = wr_bank_q;
                    rd_addr_d = '0;
                end
            end
            ST_READ: begin
                if (rd_addr_q == c_LAST) begin
                    rd_addr_d = '0;
                    if (w_drain_req) begin
                        rd_bank_d = wr_bank_q;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    rd_addr_d = rd_addr_q + c_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Read FSM outputs: issue one RAM read per cycle while draining
    always_comb begin
        w_rd_en = (state_q == ST_READ);
    end

    fft_bitrev_reorder_sdp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (2 * N),
        .AW         (AW + 1)
    ) u_ram (
        .clk     (clk),
        .we_i    (w_we),
        .waddr_i ({wr_bank_q, w_wr_rev}),
        .wdata_i (bus.di),
        .re_i    (w_rd_en),
        .raddr_i ({rd_bank_q, rd_addr_q}),
        .rdata_o (w_ram_rdata)
    );

    // Delay read-issue flag and address by one cycle to line up with RAM data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ctr_q   <= '0;
        end else begin
            valid_q <= w_rd_en;
            ctr_q   <= w_rd_en ? rd_addr_q : '0;
        end
    end

    assign bus.valid_o = valid_q;
    assign bus.ctr_o   = ctr_q;
    assign bus.data_o  = valid_q ? w_ram_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_fft_bitrev_reorder.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_bitrev_reorder
// Brief    : Self-checking bench for fft_bitrev_reorder with an N=8 and an
//            N=1024 instance, checked against a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_bitrev_reorder;

    localparam int DW = 25;
    localparam int NS = 8;
    localparam int NL = 1024;

    typedef struct {
        int cyc;
        int data;
        int bin;
    } exp_t;

    logic clk;
    logic rst8_n;
    logic rst1k_n;

    int n_checks;
    int n_fails;
    int p;
    int in_cnt [2];
    int in_buf [2][NL];
    int vcount [2];
    exp_t q_exp [2][$];

    fft_bitrev_reorder_if #(.DATA_WIDTH(DW), .N(NS)) if8 ();
    fft_bitrev_reorder_if #(.DATA_WIDTH(DW), .N(NL)) if1k ();

    fft_bitrev_reorder #(.DATA_WIDTH(DW), .N(NS)) u_dut8 (
        .clk   (clk),
        .rst_n (rst8_n),
        .bus   (if8.slave)
    );

    fft_bitrev_reorder #(.DATA_WIDTH(DW), .N(NL)) u_dut1k (
        .clk   (clk),
        .rst_n (rst1k_n),
        .bus   (if1k.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, p);
        end
    endtask

    // Reference bit reversal by repeated halving
    function automatic int ref_bitrev(input int v, input int bits);
        int r;
        int t;
        r = 0;
        t = v;
        for (int i = 0; i < bits; i++) begin
            r = r * 2 + (t % 2);
            t = t / 2;
        end
        return r;
    endfunction

    // Frame-level model: once N samples are in, bin j = sample bitrev(j),
    // emerging 2 cycles after the last sample plus j.
    task automatic model_step(input int inst, input int n, input int bits,
                              input int v, input int d, input int c,
                              input int r, input int e, input int din);
        exp_t  x;
        string s;
        s = (inst == 0) ? "n8" : "n1k";
        if (q_exp[inst].size() > 0 && q_exp[inst][0].cyc == p) begin
            x = q_exp[inst].pop_front();
            check_eq({s, "_valid"}, v, 1);
            check_eq({s, "_data"},  d, x.data);
            check_eq({s, "_ctr"},   c, x.bin);
        end else begin
            check_eq({s, "_idle_valid"}, v, 0);
            check_eq({s, "_idle_data"},  d, 0);
            check_eq({s, "_idle_ctr"},   c, 0);
        end
        if (v != 0) vcount[inst]++;
        if (r == 0) begin
            in_cnt[inst] = 0;
            q_exp[inst].delete();
        end else if (e != 0) begin
            in_buf[inst][in_cnt[inst]] = din;
            in_cnt[inst]++;
            if (in_cnt[inst] == n) begin
                for (int j = 0; j < n; j++) begin
                    x.cyc  = p + 2 + j;
                    x.data = in_buf[inst][ref_bitrev(j, bits)];
                    x.bin  = j;
                    q_exp[inst].push_back(x);
                end
                in_cnt[inst] = 0;
            end
        end
    endtask

    always @(posedge clk) p <= p + 1;

    always @(negedge clk) begin
        model_step(0, NS, 3,  int'(if8.valid_o),  int'(if8.data_o),  int'(if8.ctr_o),
                   int'(rst8_n),  int'(if8.en_i),  int'(if8.di));
        model_step(1, NL, 10, int'(if1k.valid_o), int'(if1k.data_o), int'(if1k.ctr_o),
                   int'(rst1k_n), int'(if1k.en_i), int'(if1k.di));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle8(input int k);
        if8.en_i = 1'b0;
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic send8(input int base, input int len);
        for (int i = 0; i < len; i++) begin
            if8.en_i = 1'b1;
            if8.di   = DW'(base + i);
            step();
        end
        if8.en_i = 1'b0;
    endtask

    initial begin
        int got;
        int acc;
        n_checks = 0;
        n_fails  = 0;
        p        = 0;
        for (int k = 0; k < 2; k++) begin
            in_cnt[k] = 0;
            vcount[k] = 0;
        end
        rst8_n    = 1'b0;
        rst1k_n   = 1'b0;
        if8.en_i  = 1'b0;
        if8.di    = '0;
        if1k.en_i = 1'b0;
        if1k.di   = '0;
        for (int i = 0; i < 3; i++) step();
        check_eq("reset_valid", int'(if8.valid_o), 0);
        check_eq("reset_ctr",   int'(if8.ctr_o),   0);
        rst8_n = 1'b1;
        step();

        // Single frame 0..7
        send8(0, 8);
        idle8(12);

        // Three back-to-back frames 0..23
        send8(0, 24);
        idle8(12);

        // Alternating enable across one frame
        for (int i = 0; i < 8; i++) begin
            if8.en_i = 1'b1;
            if8.di   = DW'(i);
            step();
            if8.en_i = 1'b0;
            step();
        end
        idle8(12);

        // Reset mid-frame, then a clean frame
        send8(50, 5);
        rst8_n = 1'b0;
        step();
        rst8_n = 1'b1;
        send8(100, 8);
        idle8(12);

        // Reset mid-drain at ctr_o = 3, then a clean frame
        send8(200, 8);
        got = 0;
        for (int i = 0; i < 30 && got == 0; i++) begin
            if (if8.valid_o && if8.ctr_o == 3'd3) got = 1;
            else step();
        end
        check_eq("drain_ctr3_seen", got, 1);
        rst8_n = 1'b0;
        step();
        check_eq("post_rst_valid", int'(if8.valid_o), 0);
        check_eq("post_rst_data",  int'(if8.data_o),  0);
        check_eq("post_rst_ctr",   int'(if8.ctr_o),   0);
        rst8_n = 1'b1;
        send8(300, 8);
        idle8(12);

        // Random enable gaps and data over five frames
        acc = 0;
        while (acc < 5 * NS) begin
            if8.en_i = 1'($urandom_range(0, 1));
            if8.di   = DW'($urandom_range(0, (1 << DW) - 1));
            if (if8.en_i) acc++;
            step();
        end
        idle8(12);

        // N=1024: four continuous frames of random data
        rst1k_n = 1'b1;
        step();
        for (int i = 0; i < 4 * NL; i++) begin
            if1k.en_i = 1'b1;
            if1k.di   = DW'($urandom_range(0, (1 << DW) - 1));
            step();
        end
        if1k.en_i = 1'b0;
        for (int i = 0; i < NL + 10; i++) step();

        check_eq("n1k_valid_cycles", vcount[1], 4 * NL);
        check_eq("n8_pending",  q_exp[0].size(), 0);
        check_eq("n1k_pending", q_exp[1].size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
